program_counter_unit: RTL and testbench

PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

---
 rtl/program_counter_unit_pkg.sv | 23 ++
 rtl/program_counter_unit_call_stack.sv | 46 ++++
 rtl/program_counter_unit.sv | 86 ++++++++
 tb/tb_program_counter_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/program_counter_unit_pkg.sv
// Shared widths, stack geometry and next-PC source encodings for the PC unit.
package program_counter_unit_pkg;

  localparam int unsigned PC_WIDTH    = 10;
  localparam int unsigned STACK_DEPTH = 8;
  localparam int unsigned ADDR_WIDTH  = $clog2(STACK_DEPTH);
  localparam int unsigned DEPTH_WIDTH = $clog2(STACK_DEPTH + 1);

  // Next-PC source select carried on j_mode.
  typedef enum logic [1:0] {
    JM_SEQ  = 2'b00,
    JM_ABS  = 2'b01,
    JM_RET  = 2'b10,
    JM_SKIP = 2'b11
  } j_mode_e;

  // PC addition; the result width makes it wrap modulo 2**PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] pc_add(input logic [PC_WIDTH-1:0] a,
                                                 input logic [PC_WIDTH-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/program_counter_unit_call_stack.sv
// call_stack: LIFO of return addresses, STACK_DEPTH x PC_WIDTH.
// Ports:
//   clk, rst        clock, async active-low reset (clears entries and depth)
//   push, pop       push din / drop top entry; push wins if both asserted
//   din             value to push
//   dout_c          current top entry (0 when empty)
//   depth           registered count of valid entries
//   full_c, empty_c depth at STACK_DEPTH / zero
module call_stack
  import program_counter_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [PC_WIDTH-1:0]    din,
  output logic [PC_WIDTH-1:0]    dout_c,
  output logic [DEPTH_WIDTH-1:0] depth,
  output logic                   full_c,
  output logic                   empty_c
);

  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];

  assign full_c  = (depth == DEPTH_WIDTH'(STACK_DEPTH));
  assign empty_c = (depth == '0);
  assign dout_c  = empty_c ? '0 : mem[ADDR_WIDTH'(depth - DEPTH_WIDTH'(1))];

  // Push on a full stack and pop on an empty stack leave storage untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        mem[i] <= '0;
      end
      depth <= '0;
    end else if (push) begin
      if (!full_c) begin
        mem[ADDR_WIDTH'(depth)] <= din;
        depth                   <= depth + DEPTH_WIDTH'(1);
      end
    end else if (pop && !empty_c) begin
      depth <= depth - DEPTH_WIDTH'(1);
    end
  end

endmodule

// File: rtl/program_counter_unit.sv
// program_counter_unit: program counter with next-PC mux, call/return stack,
// one-cycle-latency return register and sticky stack error flags.
// Ports:
//   clk, rst     clock, async active-low reset
//   PCw          PC write enable
//   jump         jump request
//   j_mode       next-PC source (seq / absolute / return / conditional skip)
//   call, ret    push pc+1 (needs jump and PCw) / pop top into ret_reg
//   target       absolute jump address
//   z_flag       zero flag for conditional skip
//   pc           current program counter
//   stack_depth  valid call-stack entries, 0..8
//   stack_ovf    sticky: push attempted on a full stack
//   stack_unf    sticky: pop attempted on an empty stack
module program_counter_unit
  import program_counter_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PCw,
  input  logic                   jump,
  input  logic [1:0]             j_mode,
  input  logic                   call,
  input  logic                   ret,
  input  logic [PC_WIDTH-1:0]    target,
  input  logic                   z_flag,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [DEPTH_WIDTH-1:0] stack_depth,
  output logic                   stack_ovf,
  output logic                   stack_unf
);

  logic                push_c;
  logic                pop_c;
  logic                full_c;
  logic                empty_c;
  logic [PC_WIDTH-1:0] top_c;
  logic [PC_WIDTH-1:0] pc_inc1_c;
  logic [PC_WIDTH-1:0] pc_next_c;
  logic [PC_WIDTH-1:0] ret_reg;

  // A call only counts when it is an actual PC-writing jump; it overrides ret.
  assign push_c    = call & jump & PCw;
  assign pop_c     = ret & ~push_c;
  assign pc_inc1_c = pc_add(pc, PC_WIDTH'(1));

  call_stack u_call_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .din     (pc_inc1_c),
    .dout_c  (top_c),
    .depth   (stack_depth),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // Next-PC select; return ignores jump, the others need it to leave sequence.
  always_comb begin
    pc_next_c = pc_inc1_c;
    case (j_mode_e'(j_mode))
      JM_ABS:  if (jump) pc_next_c = target;
      JM_RET:  pc_next_c = ret_reg;
      JM_SKIP: if (jump && z_flag) pc_next_c = pc_add(pc, PC_WIDTH'(2));
      default: pc_next_c = pc_inc1_c;
    endcase
  end

  // PC, return register and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= '0;
      ret_reg   <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      if (PCw) pc <= pc_next_c;
      // top_c reads as zero on an empty stack, giving the underflow value.
      if (pop_c) ret_reg <= top_c;
      if (push_c && full_c) stack_ovf <= 1'b1;
      if (pop_c && empty_c) stack_unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit with a queue-based reference model.
module tb_program_counter_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       PCw, jump, call, ret, z_flag;
  logic [1:0] j_mode;
  logic [9:0] target;
  logic [9:0] pc;
  logic [3:0] stack_depth;
  logic       stack_ovf, stack_unf;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int m_pc;
  int m_ret;
  int m_stk[$];
  int m_ovf;
  int m_unf;
  bit chk_en = 1'b0;

  program_counter_unit dut (
    .clk         (clk),
    .rst         (rst),
    .PCw         (PCw),
    .jump        (jump),
    .j_mode      (j_mode),
    .call        (call),
    .ret         (ret),
    .target      (target),
    .z_flag      (z_flag),
    .pc          (pc),
    .stack_depth (stack_depth),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_ret = 0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Applies the architectural rules to the inputs present at this edge.
  task automatic model_step();
    int  old_pc;
    bit  do_push;
    old_pc  = m_pc;
    do_push = call && jump && PCw;
    if (PCw) begin
      if (j_mode == 2'd1 && jump)      m_pc = int'(target);
      else if (j_mode == 2'd2)         m_pc = m_ret;
      else if (j_mode == 2'd3 && jump) m_pc = (old_pc + (z_flag ? 2 : 1)) % 1024;
      else                             m_pc = (old_pc + 1) % 1024;
    end
    if (do_push) begin
      if (m_stk.size() == 8) m_ovf = 1;
      else m_stk.push_back((old_pc + 1) % 1024);
    end else if (ret) begin
      if (m_stk.size() == 0) begin
        m_ret = 0;
        m_unf = 1;
      end else begin
        m_ret = m_stk.pop_back();
      end
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", int'(pc), m_pc);
      check("stack_depth", int'(stack_depth), m_stk.size());
      check("stack_ovf", int'(stack_ovf), m_ovf);
      check("stack_unf", int'(stack_unf), m_unf);
    end
  end

  task automatic cyc(input int w, input int j, input int jm, input int c,
                     input int r, input int t, input int z);
    @(negedge clk);
    #1;
    PCw    = 1'(w);
    jump   = 1'(j);
    j_mode = 2'(jm);
    call   = 1'(c);
    ret    = 1'(r);
    target = 10'(t);
    z_flag = 1'(z);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    PCw = 1'b0; jump = 1'b0; j_mode = 2'd0; call = 1'b0;
    ret = 1'b0; target = '0; z_flag = 1'b0;
  endtask

  // Asynchronous reset pulse asserted mid-cycle, released after the next negedge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    idle_inputs();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b0;
    #12;
    check("reset_pc", int'(pc), 0);
    check("reset_depth", int'(stack_depth), 0);
    check("reset_flags", int'({stack_ovf, stack_unf}), 0);
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Sequential stepping and hold
    repeat (5) cyc(1, 0, 0, 0, 0, 0, 0);
    check("seq_pc5", int'(pc), 'h005);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    check("hold_pc5", int'(pc), 'h005);

    // Jumps, skips and wrap
    cyc(1, 1, 1, 0, 0, 'h3FF, 0);
    check("abs_3ff", int'(pc), 'h3FF);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("wrap_000", int'(pc), 'h000);
    cyc(1, 1, 1, 0, 0, 'h155, 0);
    check("abs_155", int'(pc), 'h155);
    cyc(1, 1, 3, 0, 0, 0, 1);
    check("skip_z1", int'(pc), 'h157);
    cyc(1, 1, 3, 0, 0, 0, 0);
    check("skip_z0", int'(pc), 'h158);
    cyc(1, 0, 3, 0, 0, 0, 1);
    check("skip_nojump", int'(pc), 'h159);
    cyc(1, 0, 1, 0, 0, 'h200, 0);
    check("abs_nojump", int'(pc), 'h15A);
    cyc(1, 1, 1, 0, 0, 'h3FF, 0);
    cyc(1, 1, 3, 0, 0, 0, 1);
    check("skip_wrap", int'(pc), 'h001);

    // Call / return
    cyc(1, 1, 1, 0, 0, 'h020, 0);
    cyc(0, 1, 1, 1, 0, 'h300, 0);
    check("call_no_pcw", int'(stack_depth), 0);
    cyc(1, 1, 1, 1, 0, 'h100, 0);
    check("call_pc", int'(pc), 'h100);
    check("call_depth", int'(stack_depth), 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check("ret_depth", int'(stack_depth), 0);
    cyc(1, 0, 2, 0, 0, 0, 0);
    check("ret_pc", int'(pc), 'h021);
    cyc(1, 0, 0, 1, 0, 0, 0);
    check("call_no_jump", int'(stack_depth), 0);

    // Simultaneous call and return at depth 3
    do_reset();
    cyc(1, 1, 1, 1, 0, 'h010, 0);
    cyc(1, 1, 1, 1, 0, 'h020, 0);
    cyc(1, 1, 1, 1, 0, 'h030, 0);
    cyc(1, 1, 1, 1, 1, 'h080, 0);
    check("callret_depth", int'(stack_depth), 4);
    check("callret_pc", int'(pc), 'h080);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 2, 0, 0, 0, 0);
    check("callret_pushed", int'(pc), 'h031);

    // Overflow then underflow
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1, 1, 1, 1, 0, 'h040 + i, 0);
    check("ovf_depth", int'(stack_depth), 8);
    check("ovf_flag", int'(stack_ovf), 1);
    check("ovf_jump", int'(pc), 'h048);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    check("unf_depth", int'(stack_depth), 0);
    check("unf_flag", int'(stack_unf), 1);
    check("ovf_sticky", int'(stack_ovf), 1);
    cyc(1, 0, 2, 0, 0, 0, 0);
    check("unf_ret_pc", int'(pc), 'h000);

    // Reset between a pop and its return load
    cyc(1, 1, 1, 1, 0, 'h077, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    #2;
    idle_inputs();
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_pc", int'(pc), 0);
    check("arst_depth", int'(stack_depth), 0);
    check("arst_flags", int'({stack_ovf, stack_unf}), 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    cyc(1, 0, 2, 0, 0, 0, 0);
    check("arst_ret_cleared", int'(pc), 'h000);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check("post_reset_seq", int'(pc), 'h001);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
